encrypt_sched: RTL and testbench
================================

Name: encrypt_sched

Overview:
Sequencer for the per-pixel XOR encryption datapath. On `start`, it walks every pixel address once and pulls one R/G/B keystream triple per pixel from the chaotic LFSR key generator over a valid/request handshake. It issues a read to the plain-pixel RAMs and writes the XORed triple to the encrypted-pixel RAMs one cycle later. It sits between the key generator, the three plain-image block RAMs and the three encrypted-image block RAMs, and reports busy, done and error status to the top level.

Parameters:
ADDR_W, 14, pixel address width
NUM_PIX, 16384, pixels per frame; legal range 1..2**ADDR_W
DATA_W, 8, bits per colour channel
KS_TIMEOUT, 255, max consecutive stalled cycles waiting for the keystream before error; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when in IDLE, DONE or ERR
abort  in  1  one-cycle pulse; cancels the frame in progress
ks_req  out  1  keystream request, high in RUN
ks_valid  in  1  keystream triple available; a transfer occurs when ks_req && ks_valid
ks_r, ks_g, ks_b  in  DATA_W each  keystream bytes
rd_en  out  1  plain RAM read enable
rd_addr  out  ADDR_W  plain RAM read address
rd_r, rd_g, rd_b  in  DATA_W each  plain RAM data, valid exactly 1 cycle after rd_en
wr_en  out  1  encrypted RAM write enable
wr_addr  out  ADDR_W  encrypted RAM write address
wr_r, wr_g, wr_b  out  DATA_W each  encrypted bytes
busy  out  1  high in RUN or DRAIN
done  out  1  level, high in DONE
ks_err  out  1  level, high in ERR
pix_cnt  out  ADDR_W+1  pixels written this frame

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0: ks_req, rd_en, wr_en, rd_addr, wr_addr, wr_*, busy, done, ks_err, pix_cnt. Stage-1 registers cleared. Stall counter 0.
- States:
  - IDLE: start -> RUN; clear addr, pix_cnt and stall counter.
  - RUN: ks_req=1.
    - On transfer: rd_en=1 combinationally with rd_addr=addr; latch ks_* and addr into stage 1; addr++.
    - On the transfer with addr==NUM_PIX-1 -> DRAIN.
  - DRAIN: ks_req=0; finishes the stage-1 write -> DONE.
  - DONE: done=1; start -> RUN (done drops the same edge).
  - ERR: ks_err=1; start -> RUN (clears ks_err).
- Datapath latency: stage-1 valid is set the cycle after a transfer. In that cycle:
  - wr_en=1
  - wr_addr = latched addr
  - wr_x = rd_x ^ ks_x_latched
  - pix_cnt increments on each wr_en.
- Throughput: 1 pixel/cycle when ks_valid is held high. A frame of N pixels takes N+2 cycles from start to done, including the DRAIN cycle.
- rd_en/rd_addr are combinational from ks_valid and the state. wr_* are driven from registers plus the rd_* inputs; no extra register on the RAM side.
- Stall counter: increments each RUN cycle with ks_req && !ks_valid; resets on any transfer.
  - When it reaches KS_TIMEOUT (nonzero) -> ERR.
  - A pending stage-1 write still completes on that edge; no further reads.
- abort in RUN or DRAIN -> IDLE. The pending stage-1 write is squashed (wr_en=0 that cycle); pix_cnt holds its value. abort in IDLE, DONE or ERR is ignored.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- addr never wraps: the last index is NUM_PIX-1. pix_cnt reaches NUM_PIX exactly.
- Async reset mid-frame: immediate IDLE, no write emitted after reset assertion.

Decomposition:
- Package encrypt_pkg: state enum (IDLE, RUN, DRAIN, DONE, ERR), default ADDR_W/DATA_W/NUM_PIX constants, rgb_t struct of three DATA_W fields.
- One sub-module, xor_stage: the stage-1 register plus the XOR, with valid/addr/keystream in and wr_* out. The FSM and counters stay in encrypt_sched.

Test Plan:
- NUM_PIX=4, ks_valid constantly 1, plain data = address, keystream = 8'hA5. Required: writes at addresses 0..3 with data addr^A5; done high on cycle 6 after start; pix_cnt=4.
- ks_valid toggling 1,0,1,0. Required: no write in a cycle not preceded by a transfer; order and data intact; done only after 4 writes.
- KS_TIMEOUT=3, ks_valid held low after 2 transfers. Required: ks_err after exactly 3 stalled cycles; 2 writes completed; a subsequent start clears ks_err and restarts at addr 0.
- abort in the cycle after the 2nd transfer. Required: that write is squashed; state IDLE; pix_cnt=1; done=0.
- rst_n asserted mid-RUN. Required: all outputs 0 asynchronously; a fresh start completes the full frame correctly.
- start pulsed while busy, and start+abort together. Required: the first is ignored; the second yields IDLE.

Source files
------------

// File: rtl/encrypt_sched_pkg.sv
// -----------------------------------------------------------------------------
// encrypt_pkg
// Shared types and default sizes for the per-pixel XOR encryption sequencer.
//   state_t : sequencer states (IDLE, RUN, DRAIN, DONE, ERR)
//   rgb_t   : one R/G/B triple at the default channel width
// -----------------------------------------------------------------------------
package encrypt_pkg;

  localparam int DEF_ADDR_W     = 14;
  localparam int DEF_NUM_PIX    = 16384;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_KS_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] r;
    logic [DEF_DATA_W-1:0] g;
    logic [DEF_DATA_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/encrypt_sched_xor_stage.sv
// -----------------------------------------------------------------------------
// xor_stage
// Stage-1 register of the encryption datapath. Captures the pixel address and
// keystream triple on a transfer, then one cycle later XORs the keystream with
// the plain-RAM read data (which arrives exactly then) and drives the write.
//   clk, rst_n            : clock, async active-low reset
//   i_vld                 : a keystream transfer happened this cycle
//   i_addr, i_ks_r/g/b    : address and keystream captured on i_vld
//   i_squash              : suppress the pending write this cycle (abort)
//   i_rd_r/g/b            : plain RAM read data for the captured address
//   o_wr_en, o_wr_addr    : encrypted RAM write enable / address
//   o_wr_r/g/b            : encrypted bytes
// -----------------------------------------------------------------------------
module xor_stage
  import encrypt_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_ks_r,
  input  logic [DATA_W-1:0] i_ks_g,
  input  logic [DATA_W-1:0] i_ks_b,
  input  logic              i_squash,
  input  logic [DATA_W-1:0] i_rd_r,
  input  logic [DATA_W-1:0] i_rd_g,
  input  logic [DATA_W-1:0] i_rd_b,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_r,
  output logic [DATA_W-1:0] o_wr_g,
  output logic [DATA_W-1:0] o_wr_b
);

  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_ks_r_p1;
  logic [DATA_W-1:0] r_ks_g_p1;
  logic [DATA_W-1:0] r_ks_b_p1;

  // ---- stage 0 -> stage 1: capture address and keystream on transfer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_ks_r_p1 <= '0;
      r_ks_g_p1 <= '0;
      r_ks_b_p1 <= '0;
    end else begin
      r_vld_p1 <= i_vld;
      if (i_vld) begin
        r_addr_p1 <= i_addr;
        r_ks_r_p1 <= i_ks_r;
        r_ks_g_p1 <= i_ks_g;
        r_ks_b_p1 <= i_ks_b;
      end
    end
  end

  // ---- stage 1: RAM data lands now; XOR straight onto the write port ----
  // Data is gated by the enable so idle/reset cycles present zeros.
  assign o_wr_en   = r_vld_p1 && !i_squash;
  assign o_wr_addr = r_addr_p1;
  assign o_wr_r    = o_wr_en ? (i_rd_r ^ r_ks_r_p1) : '0;
  assign o_wr_g    = o_wr_en ? (i_rd_g ^ r_ks_g_p1) : '0;
  assign o_wr_b    = o_wr_en ? (i_rd_b ^ r_ks_b_p1) : '0;

endmodule

// File: rtl/encrypt_sched.sv
// -----------------------------------------------------------------------------
// encrypt_sched
// Frame sequencer for the per-pixel XOR encryption datapath. Walks pixel
// addresses 0..NUM_PIX-1, pulling one keystream triple per pixel, reading the
// plain RAMs on each transfer and writing the encrypted RAMs one cycle later.
//   clk, rst_n          : clock, async active-low reset
//   start, abort        : frame control pulses (abort wins when both high)
//   ks_req, ks_valid    : keystream handshake; transfer = ks_req && ks_valid
//   ks_r/g/b            : keystream bytes
//   rd_en, rd_addr      : plain RAM read port (combinational from transfer)
//   rd_r/g/b            : plain RAM data, one cycle after rd_en
//   wr_en, wr_addr      : encrypted RAM write port
//   wr_r/g/b            : encrypted bytes
//   busy, done, ks_err  : status levels
//   pix_cnt             : pixels written this frame
// -----------------------------------------------------------------------------
module encrypt_sched
  import encrypt_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_PIX    = DEF_NUM_PIX,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int KS_TIMEOUT = DEF_KS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              ks_req,
  input  logic              ks_valid,
  input  logic [DATA_W-1:0] ks_r,
  input  logic [DATA_W-1:0] ks_g,
  input  logic [DATA_W-1:0] ks_b,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_r,
  input  logic [DATA_W-1:0] rd_g,
  input  logic [DATA_W-1:0] rd_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_r,
  output logic [DATA_W-1:0] wr_g,
  output logic [DATA_W-1:0] wr_b,
  output logic              busy,
  output logic              done,
  output logic              ks_err,
  output logic [ADDR_W:0]   pix_cnt
);

  // The stall counter only needs to reach KS_TIMEOUT-1: the next stalled
  // cycle is the one that trips the error.
  localparam int ST_W = (KS_TIMEOUT > 1) ? $clog2(KS_TIMEOUT) : 1;
  localparam logic [ST_W-1:0]   STALL_LIM = ST_W'((KS_TIMEOUT > 0) ? KS_TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_pix_cnt;
  logic [ST_W-1:0]   r_stall;

  logic w_run;
  logic w_busy;
  logic w_idle_like;
  logic w_xfer;
  logic w_last;
  logic w_timeout;
  logic w_start_act;
  logic w_abort_act;
  logic w_wr_en;

  assign w_run       = (r_state == RUN);
  assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
  assign w_xfer      = w_run && ks_valid;
  assign w_last      = (r_addr == LAST_ADDR);
  assign w_timeout   = (KS_TIMEOUT != 0) && w_run && !ks_valid && (r_stall == STALL_LIM);
  assign w_start_act = start && !abort && w_idle_like;
  assign w_abort_act = abort && w_busy;

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE, ERR: if (w_start_act) w_state_nxt = RUN;
      RUN: begin
        if (abort)                 w_state_nxt = IDLE;
        else if (w_xfer && w_last) w_state_nxt = DRAIN;
        else if (w_timeout)        w_state_nxt = ERR;
      end
      DRAIN: begin
        if (abort) w_state_nxt = IDLE;
        else       w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- frame counters: address, stall run length, pixels written ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_pix_cnt <= '0;
      r_stall   <= '0;
    end else if (w_start_act) begin
      r_addr    <= '0;
      r_pix_cnt <= '0;
      r_stall   <= '0;
    end else begin
      if (w_xfer && !abort) begin
        r_stall <= '0;
        // Hold on the last index so a full 2**ADDR_W frame never wraps.
        if (!w_last) r_addr <= r_addr + ADDR_W'(1);
      end else if (w_run && !ks_valid) begin
        r_stall <= r_stall + ST_W'(1);
      end
      if (w_wr_en) r_pix_cnt <= r_pix_cnt + (ADDR_W + 1)'(1);
    end
  end

  // ---- stage 0: keystream handshake and plain RAM read ----
  assign ks_req  = w_run;
  assign rd_en   = w_xfer;
  assign rd_addr = r_addr;

  xor_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xor_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_vld     (w_xfer && !abort),
    .i_addr    (r_addr),
    .i_ks_r    (ks_r),
    .i_ks_g    (ks_g),
    .i_ks_b    (ks_b),
    .i_squash  (w_abort_act),
    .i_rd_r    (rd_r),
    .i_rd_g    (rd_g),
    .i_rd_b    (rd_b),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_r    (wr_r),
    .o_wr_g    (wr_g),
    .o_wr_b    (wr_b)
  );

  assign wr_en   = w_wr_en;
  assign busy    = w_busy;
  assign done    = (r_state == DONE);
  assign ks_err  = (r_state == ERR);
  assign pix_cnt = r_pix_cnt;

endmodule

// File: tb/tb_encrypt_sched.sv
module tb_encrypt_sched;

  localparam int AW = 3;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int KT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ks_valid = 1'b0;
  logic [DW-1:0] ks_r = '0;
  logic [DW-1:0] ks_g = '0;
  logic [DW-1:0] ks_b = '0;
  logic [DW-1:0] rd_r = '0;
  logic [DW-1:0] rd_g = '0;
  logic [DW-1:0] rd_b = '0;
  logic          ks_req, rd_en, wr_en, busy, done, ks_err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_r, wr_g, wr_b;
  logic [AW:0]   pix_cnt;

  int n_checks = 0;
  int n_errors = 0;

  encrypt_sched #(
    .ADDR_W     (AW),
    .NUM_PIX    (NP),
    .DATA_W     (DW),
    .KS_TIMEOUT (KT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .ks_req   (ks_req),
    .ks_valid (ks_valid),
    .ks_r     (ks_r),
    .ks_g     (ks_g),
    .ks_b     (ks_b),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_r     (rd_r),
    .rd_g     (rd_g),
    .rd_b     (rd_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_r     (wr_r),
    .wr_g     (wr_g),
    .wr_b     (wr_b),
    .busy     (busy),
    .done     (done),
    .ks_err   (ks_err),
    .pix_cnt  (pix_cnt)
  );

  always #5 clk = ~clk;

  // Plain image: R = address, G = address+0x10, B = address+0x20.
  function automatic logic [7:0] pl(input int ch, input int a);
    return 8'(a + 16 * ch);
  endfunction

  // Plain RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_r <= pl(0, int'(rd_addr));
      rd_g <= pl(1, int'(rd_addr));
      rd_b <= pl(2, int'(rd_addr));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; keystream channels derive from k.
  task automatic tick(input logic s, input logic a, input logic v, input logic [7:0] k);
    @(negedge clk);
    start    = s;
    abort    = a;
    ks_valid = v;
    ks_r     = k;
    ks_g     = k ^ 8'h0F;
    ks_b     = k ^ 8'hF0;
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic en, input int a, input logic [7:0] k);
    chk({tag, ".wr_en"}, wr_en, en);
    if (en) begin
      chk({tag, ".wr_addr"}, wr_addr, a);
      chk({tag, ".wr_r"}, wr_r, pl(0, a) ^ k);
      chk({tag, ".wr_g"}, wr_g, pl(1, a) ^ (k ^ 8'h0F));
      chk({tag, ".wr_b"}, wr_b, pl(2, a) ^ (k ^ 8'hF0));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ks_req"}, ks_req, 0);
    chk({tag, ".rd_en"}, rd_en, 0);
    chk({tag, ".rd_addr"}, rd_addr, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_rgb"}, {wr_r, wr_g, wr_b}, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".ks_err"}, ks_err, 0);
    chk({tag, ".pix_cnt"}, pix_cnt, 0);
  endtask

  // Full frame with ks_valid held high and a constant keystream.
  task automatic full_frame(input string tag, input logic [7:0] k);
    tick(1, 0, 1, k);
    chk({tag, ".start_busy"}, busy, 0);
    for (int i = 0; i < NP; i++) begin
      tick(0, 0, 1, k);
      chk({tag, ".rd_en"}, rd_en, 1);
      chk({tag, ".rd_addr"}, rd_addr, i);
      chk({tag, ".busy"}, busy, 1);
      chk_wr(tag, i > 0, i - 1, k);
    end
    tick(0, 0, 0, 8'h00);
    chk({tag, ".drain_ks_req"}, ks_req, 0);
    chk({tag, ".drain_busy"}, busy, 1);
    chk({tag, ".drain_done"}, done, 0);
    chk_wr({tag, ".drain"}, 1, NP - 1, k);
    tick(0, 0, 0, 8'h00);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".done_busy"}, busy, 0);
    chk({tag, ".pix_cnt"}, pix_cnt, NP);
    chk({tag, ".done_wr_en"}, wr_en, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: done on the 6th cycle after the start cycle
    full_frame("frame_a5", 8'hA5);

    // ks_valid toggling 1,0,1,0
    tick(1, 0, 0, 8'h00);
    for (int i = 0; i < NP; i++) begin
      tick(0, 0, 1, 8'(8'h30 + 8'(i * 7)));
      chk("tog.rd_en", rd_en, 1);
      chk("tog.rd_addr", rd_addr, i);
      chk("tog.pix_cnt", pix_cnt, i);
      chk("tog.no_wr", wr_en, 0);
      tick(0, 0, 0, 8'hFF);
      chk("tog.stall_rd_en", rd_en, 0);
      chk("tog.done_early", done, 0);
      chk_wr("tog", 1, i, 8'(8'h30 + 8'(i * 7)));
    end
    tick(0, 0, 0, 8'h00);
    chk("tog.done", done, 1);
    chk("tog.pix_cnt_end", pix_cnt, NP);

    // Keystream timeout after 2 transfers
    tick(1, 0, 0, 8'h00);
    tick(0, 0, 1, 8'h11);
    tick(0, 0, 1, 8'h22);
    chk_wr("to.w0", 1, 0, 8'h11);
    tick(0, 0, 0, 8'h00);
    chk_wr("to.w1", 1, 1, 8'h22);
    chk("to.err_s1", ks_err, 0);
    tick(0, 0, 0, 8'h00);
    chk("to.err_s2", ks_err, 0);
    chk("to.busy_s2", busy, 1);
    chk("to.wr_s2", wr_en, 0);
    tick(0, 0, 0, 8'h00);
    chk("to.err_s3", ks_err, 0);
    chk("to.rd_s3", rd_en, 0);
    tick(0, 0, 0, 8'h00);
    chk("to.err", ks_err, 1);
    chk("to.err_busy", busy, 0);
    chk("to.err_ks_req", ks_req, 0);
    chk("to.err_pix", pix_cnt, 2);
    chk("to.err_wr", wr_en, 0);

    // Restart out of ERR, then abort the cycle after the 2nd transfer
    tick(1, 0, 1, 8'h44);
    chk("rs.err_hold", ks_err, 1);
    chk("rs.no_rd", rd_en, 0);
    tick(0, 0, 1, 8'h55);
    chk("rs.err_clr", ks_err, 0);
    chk("rs.rd_en", rd_en, 1);
    chk("rs.rd_addr0", rd_addr, 0);
    chk("rs.pix0", pix_cnt, 0);
    tick(0, 0, 1, 8'h66);
    chk("rs.rd_addr1", rd_addr, 1);
    chk_wr("rs.w0", 1, 0, 8'h55);
    tick(0, 1, 1, 8'h77);
    chk("ab.squash", wr_en, 0);
    chk("ab.pix", pix_cnt, 1);
    tick(0, 0, 0, 8'h00);
    chk("ab.busy", busy, 0);
    chk("ab.done", done, 0);
    chk("ab.ks_req", ks_req, 0);
    chk("ab.wr_en", wr_en, 0);
    chk("ab.pix_hold", pix_cnt, 1);

    // start while busy ignored; start+abort -> IDLE
    tick(1, 0, 1, 8'h81);
    tick(0, 0, 1, 8'h82);
    chk("sb.rd_addr0", rd_addr, 0);
    tick(1, 0, 1, 8'h83);
    chk("sb.rd_addr1", rd_addr, 1);
    chk_wr("sb.w0", 1, 0, 8'h82);
    tick(0, 0, 1, 8'h84);
    chk("sb.rd_addr2", rd_addr, 2);
    chk("sb.pix1", pix_cnt, 1);
    chk_wr("sb.w1", 1, 1, 8'h83);
    tick(1, 1, 1, 8'h85);
    chk("sa.squash", wr_en, 0);
    tick(0, 0, 0, 8'h00);
    chk("sa.busy", busy, 0);
    chk("sa.ks_req", ks_req, 0);
    chk("sa.pix", pix_cnt, 2);
    tick(1, 1, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    chk("sa.idle_busy", busy, 0);
    chk("sa.idle_pix", pix_cnt, 2);

    // Async reset mid-frame
    tick(1, 0, 1, 8'h91);
    tick(0, 0, 1, 8'h92);
    tick(0, 0, 1, 8'h93);
    chk_wr("mr.pre", 1, 0, 8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mr.async");
    @(negedge clk);
    #1;
    chk_zero("mr.held");
    rst_n = 1'b1;
    full_frame("frame_3c", 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
